collision_scanner: RTL

COLLISION_SCANNER -- requirements
Module: collision_scanner

---
 rtl/collision_scanner.sv | 117 +++++++++++
 1 files changed

// File: rtl/collision_scanner.sv
// Snake body store with a one-segment-per-cycle self-collision scan.
// A proposed head is checked against the body (and the playfield bounds) before it is committed.
module collision_scanner #(
  parameter int N       = 4,
  parameter int MAX_LEN = 16,
  parameter int W       = 16,
  parameter int H       = 16,
  parameter int INIT_X  = 0,
  parameter int INIT_Y  = 0,
  localparam int LW     = $clog2(MAX_LEN + 1),
  localparam int IW     = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  head_x,
  input  logic [N-1:0]  head_y,
  input  logic          grow,
  output logic          busy,
  output logic          done,
  output logic          hit,
  output logic          oob,
  output logic [LW-1:0] len,
  input  logic [IW-1:0] rd_idx,
  output logic [N-1:0]  rd_x,
  output logic [N-1:0]  rd_y
);

  typedef enum logic [1:0] {IDLE, SCAN, UPDATE, DONE} state_t;

  state_t        state, state_nx;
  logic [N-1:0]  seg_x [MAX_LEN];
  logic [N-1:0]  seg_y [MAX_LEN];
  logic [N-1:0]  cap_x, cap_y;
  logic          cap_grow;
  logic [IW-1:0] scan_idx, scan_end;
  logic [LW-1:0] scan_len;
  logic          start_oob;

  // The tail is excluded from the scan on a plain move because it vacates this step.
  assign scan_len  = grow ? len : len - LW'(1);
  assign start_oob = (int'(head_x) >= W) || (int'(head_y) >= H);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (start_oob || scan_len == '0) ? UPDATE : SCAN;
      SCAN:    if (scan_idx == scan_end) state_nx = UPDATE;
      UPDATE:  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // done is registered off the DONE state, giving the fixed L+2 edge latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= '0;
        seg_y[i] <= '0;
      end
      seg_x[0] <= N'(INIT_X);
      seg_y[0] <= N'(INIT_Y);
      len      <= LW'(1);
      done     <= 1'b0;
      hit      <= 1'b0;
      oob      <= 1'b0;
      cap_x    <= '0;
      cap_y    <= '0;
      cap_grow <= 1'b0;
      scan_idx <= '0;
      scan_end <= '0;
      rd_x     <= '0;
      rd_y     <= '0;
    end else begin
      done <= (state == DONE);
      rd_x <= seg_x[rd_idx];
      rd_y <= seg_y[rd_idx];
      case (state)
        IDLE: begin
          if (start) begin
            cap_x    <= head_x;
            cap_y    <= head_y;
            cap_grow <= grow;
            hit      <= 1'b0;
            oob      <= start_oob;
            scan_idx <= '0;
            scan_end <= IW'(scan_len - LW'(1));
          end
        end
        SCAN: begin
          if (seg_x[scan_idx] == cap_x && seg_y[scan_idx] == cap_y) hit <= 1'b1;
          scan_idx <= scan_idx + IW'(1);
        end
        UPDATE: begin
          if (!hit && !oob) begin
            for (int i = MAX_LEN - 1; i > 0; i--) begin
              seg_x[i] <= seg_x[i-1];
              seg_y[i] <= seg_y[i-1];
            end
            seg_x[0] <= cap_x;
            seg_y[0] <= cap_y;
            if (cap_grow && len < LW'(MAX_LEN)) len <= len + LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
